top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top_pkg.sv | 28 ++
 rtl/packer.sv | 70 +++++++
 rtl/sync_fifo.sv | 71 +++++++
 rtl/uart_rx.sv | 120 ++++++++++++
 rtl/top.sv | 82 ++++++++
 tb/tb_top.sv | 289 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/top_pkg.sv
`default_nettype none
// ============================================================================
// Module      : top_pkg
// Description : Shared types and constants for the UART-to-word packer slice:
//               receiver state encoding, bit-period calculation and the
//               number of bytes gathered into one output word.
// Revision    : 1.0 - initial release
// ============================================================================
package top_pkg;

    // Receiver states, in frame order
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_t;

    // Bytes gathered into one output word
    localparam int BYTES_PER_WORD = 16;

    // Clock cycles per UART bit (integer division, truncating)
    function automatic int clks_per_bit_calc(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage
`default_nettype wire

// File: rtl/packer.sv
`default_nettype none
// ============================================================================
// Module      : packer
// Description : Drains the FIFO one byte at a time (one read in flight) and
//               assembles BYTES bytes into a word, first byte in the LSBs.
//               The finished word is held until the next one completes.
// Revision    : 1.0 - initial release
// ============================================================================
module packer
    import top_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int BYTES      = BYTES_PER_WORD
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_en,
    input  logic                        i_empty,
    input  logic                        i_rd_valid,
    input  logic [DATA_WIDTH-1:0]       i_rd_data,
    output logic                        o_rd_req,
    output logic [DATA_WIDTH*BYTES-1:0] o_word,
    output logic                        o_word_valid
);

    localparam int c_word_w = DATA_WIDTH * BYTES;
    localparam int c_cnt_w  = $clog2(BYTES);
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BYTES - 1);

    logic                r_pending;
    logic [c_cnt_w-1:0]  r_cnt;
    logic [c_word_w-1:0] r_acc;
    logic [c_word_w-1:0] r_word;
    logic                r_word_valid;
    logic                w_rd_req;

    assign w_rd_req = !rst && i_en && !i_empty && !r_pending;

    // Read handshake and byte assembly
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending    <= 1'b0;
            r_cnt        <= '0;
            r_acc        <= '0;
            r_word       <= '0;
            r_word_valid <= 1'b0;
        end else begin
            if (w_rd_req) r_pending <= 1'b1;
            else if (i_rd_valid) r_pending <= 1'b0;
            r_word_valid <= 1'b0;
            if (i_rd_valid) begin
                if (r_cnt == c_cnt_last) begin
                    // Last byte goes straight into the published word
                    r_word       <= {i_rd_data, r_acc[c_word_w-DATA_WIDTH-1:0]};
                    r_word_valid <= 1'b1;
                    r_cnt        <= '0;
                end else begin
                    r_acc[int'(r_cnt)*DATA_WIDTH +: DATA_WIDTH] <= i_rd_data;
                    r_cnt <= r_cnt + c_cnt_w'(1);
                end
            end
        end
    end

    assign o_rd_req     = w_rd_req;
    assign o_word       = r_word;
    assign o_word_valid = r_word_valid;

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with extra-MSB pointers. Writes to a full
//               FIFO are dropped; read data is registered and qualified by
//               o_rd_valid one cycle after the request. Storage is not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 1024
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_req,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_rd_valid,
    output logic                  o_full,
    output logic                  o_empty
);

    localparam int c_addr_w = $clog2(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [c_addr_w:0]     r_wr_ptr;
    logic [c_addr_w:0]     r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_rd_data;
    logic                  r_rd_valid;
    logic                  w_full;
    logic                  w_empty;
    logic                  w_do_wr;
    logic                  w_do_rd;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_addr_w-1:0] == r_rd_ptr[c_addr_w-1:0]) &&
                     (r_wr_ptr[c_addr_w] != r_rd_ptr[c_addr_w]);
    assign w_do_wr = i_wr_en && !w_full;
    assign w_do_rd = i_rd_req && !w_empty;

    // Pointer and read-valid bookkeeping
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_rd_valid <= 1'b0;
        end else begin
            if (w_do_wr) r_wr_ptr <= r_wr_ptr + (c_addr_w + 1)'(1);
            if (w_do_rd) r_rd_ptr <= r_rd_ptr + (c_addr_w + 1)'(1);
            r_rd_valid <= w_do_rd;
        end
    end

    // Storage write; contents survive reset and reads
    always_ff @(posedge clk) begin
        if (w_do_wr) mem[r_wr_ptr[c_addr_w-1:0]] <= i_wr_data;
    end

    // Registered read port
    always_ff @(posedge clk) begin
        if (w_do_rd) r_rd_data <= mem[r_rd_ptr[c_addr_w-1:0]];
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_full     = w_full;
    assign o_empty    = w_empty;

endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver, LSB first. The line is synchronised by two
//               flops, the start bit is re-checked at half a bit period and
//               every later bit is sampled one full bit period apart.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx
    import top_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_rx,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_done,
    output logic                  o_frame_err
);

    localparam int c_cnt_w = $clog2(CLKS_PER_BIT + 1);
    localparam int c_idx_w = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(CLKS_PER_BIT / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(CLKS_PER_BIT - 1);
    localparam logic [c_idx_w-1:0] c_idx_last  = c_idx_w'(DATA_WIDTH - 1);

    logic                  r_rx_meta;
    logic                  r_rx_sync;
    uart_state_t           r_state,     w_state_nxt;
    logic [c_cnt_w-1:0]    r_clk_cnt,   w_clk_cnt_nxt;
    logic [c_idx_w-1:0]    r_bit_idx,   w_bit_idx_nxt;
    logic [DATA_WIDTH-1:0] r_shift,     w_shift_nxt;
    logic                  r_done,      w_done_nxt;
    logic                  r_frame_err, w_frame_err_nxt;

    // Two-flop synchroniser; reset to the idle (high) line level
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_sync <= 1'b1;
        end else begin
            r_rx_meta <= i_rx;
            r_rx_sync <= r_rx_meta;
        end
    end

    // State, counters, shift register and result pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_clk_cnt   <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_done      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_clk_cnt   <= w_clk_cnt_nxt;
            r_bit_idx   <= w_bit_idx_nxt;
            r_shift     <= w_shift_nxt;
            r_done      <= w_done_nxt;
            r_frame_err <= w_frame_err_nxt;
        end
    end

    // Frame sequencing: start check at half bit, then whole-bit sampling
    always_comb begin
        w_state_nxt     = r_state;
        w_clk_cnt_nxt   = r_clk_cnt;
        w_bit_idx_nxt   = r_bit_idx;
        w_shift_nxt     = r_shift;
        w_done_nxt      = 1'b0;
        w_frame_err_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_clk_cnt_nxt = '0;
                w_bit_idx_nxt = '0;
                if (!r_rx_sync) w_state_nxt = ST_START;
            end
            ST_START: begin
                if (r_clk_cnt == c_half_last) begin
                    w_clk_cnt_nxt = '0;
                    // A line already back high means the falling edge was noise
                    w_state_nxt   = r_rx_sync ? ST_IDLE : ST_DATA;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_cnt_w'(1);
                end
            end
            ST_DATA: begin
                if (r_clk_cnt == c_bit_last) begin
                    w_clk_cnt_nxt = '0;
                    w_shift_nxt   = {r_rx_sync, r_shift[DATA_WIDTH-1:1]};
                    if (r_bit_idx == c_idx_last) w_state_nxt = ST_STOP;
                    else w_bit_idx_nxt = r_bit_idx + c_idx_w'(1);
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_cnt_w'(1);
                end
            end
            ST_STOP: begin
                if (r_clk_cnt == c_bit_last) begin
                    w_clk_cnt_nxt   = '0;
                    w_done_nxt      = r_rx_sync;
                    w_frame_err_nxt = !r_rx_sync;
                    w_state_nxt     = ST_IDLE;
                end else begin
                    w_clk_cnt_nxt = r_clk_cnt + c_cnt_w'(1);
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_data      = r_shift;
    assign o_done      = r_done;
    assign o_frame_err = r_frame_err;

endmodule
`default_nettype wire

// File: rtl/top.sv
`default_nettype none
// ============================================================================
// Module      : top
// Description : UART receiver feeding a byte FIFO whose contents are packed
//               into 16-byte words when draining is enabled.
// Revision    : 1.0 - initial release
// ============================================================================
module top
    import top_pkg::*;
#(
    parameter int TB_DATA_WIDTH = 8,
    parameter int TB_CLK_FREQ   = 100_000_000,
    parameter int TB_BAUD_RATE  = 115200,
    parameter int TB_DEPTH      = 1024
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  rx,
    input  logic                                  r_en,
    output logic [BYTES_PER_WORD*TB_DATA_WIDTH-1:0] word_out,
    output logic                                  word_valid,
    output logic                                  fifo_full,
    output logic                                  fifo_empty
);

    localparam int CLKS_PER_BIT = clks_per_bit_calc(TB_CLK_FREQ, TB_BAUD_RATE);

    logic [TB_DATA_WIDTH-1:0] w_rx_data;
    logic                     w_rx_done;
    logic                     w_frame_err;
    logic                     w_wr_en;
    logic                     w_rd_req;
    logic [TB_DATA_WIDTH-1:0] w_rd_data;
    logic                     w_rd_valid;

    uart_rx #(
        .DATA_WIDTH   (TB_DATA_WIDTH),
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart_rx (
        .clk         (clk),
        .rst         (rst),
        .i_rx        (rx),
        .o_data      (w_rx_data),
        .o_done      (w_rx_done),
        .o_frame_err (w_frame_err)
    );

    // Only bytes with a valid stop bit are stored
    assign w_wr_en = w_rx_done && !w_frame_err;

    sync_fifo #(
        .DATA_WIDTH (TB_DATA_WIDTH),
        .DEPTH      (TB_DEPTH)
    ) SYNC_FIFO_DUT (
        .clk        (clk),
        .rst        (rst),
        .i_wr_en    (w_wr_en),
        .i_wr_data  (w_rx_data),
        .i_rd_req   (w_rd_req),
        .o_rd_data  (w_rd_data),
        .o_rd_valid (w_rd_valid),
        .o_full     (fifo_full),
        .o_empty    (fifo_empty)
    );

    packer #(
        .DATA_WIDTH (TB_DATA_WIDTH),
        .BYTES      (BYTES_PER_WORD)
    ) u_packer (
        .clk          (clk),
        .rst          (rst),
        .i_en         (r_en),
        .i_empty      (fifo_empty),
        .i_rd_valid   (w_rd_valid),
        .i_rd_data    (w_rd_data),
        .o_rd_req     (w_rd_req),
        .o_word       (word_out),
        .o_word_valid (word_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_top.sv
`default_nettype none
// ============================================================================
// Module      : tb_top
// Description : Self-checking bench for top. Three instances share the clock
//               and reset: default bit rate (868 clocks per bit), a fast
//               16-clocks-per-bit instance, and a fast 4-deep instance.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_top;
    import top_pkg::*;

    localparam int CPB_SLOW = 868;
    localparam int CPB_FAST = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst;
    logic         rx_s, rx_f, rx_m;
    logic         en_s, en_f, en_m;
    logic [127:0] wo_s, wo_f, wo_m;
    logic         wv_s, wv_f, wv_m;
    logic         full_s, full_f, full_m;
    logic         empty_s, empty_f, empty_m;

    int n_vec = 0;
    int n_err = 0;

    logic [127:0] got_s[$];
    logic [127:0] got_f[$];
    logic [127:0] got_m[$];

    top u_slow (
        .clk(clk), .rst(rst), .rx(rx_s), .r_en(en_s), .word_out(wo_s),
        .word_valid(wv_s), .fifo_full(full_s), .fifo_empty(empty_s)
    );

    top #(.TB_BAUD_RATE(6_250_000)) u_fast (
        .clk(clk), .rst(rst), .rx(rx_f), .r_en(en_f), .word_out(wo_f),
        .word_valid(wv_f), .fifo_full(full_f), .fifo_empty(empty_f)
    );

    top #(.TB_BAUD_RATE(6_250_000), .TB_DEPTH(4)) u_small (
        .clk(clk), .rst(rst), .rx(rx_m), .r_en(en_m), .word_out(wo_m),
        .word_valid(wv_m), .fifo_full(full_m), .fifo_empty(empty_m)
    );

    // Collect every completed word
    always @(negedge clk) begin
        if (wv_s) got_s.push_back(wo_s);
        if (wv_f) got_f.push_back(wo_f);
        if (wv_m) got_m.push_back(wo_m);
    end

    task automatic drive_rx(input int sel, input logic v);
        case (sel)
            0:       rx_s = v;
            1:       rx_f = v;
            default: rx_m = v;
        endcase
    endtask

    task automatic uart_send(input int sel, input logic [7:0] b, input logic stop_bit, input int cpb);
        logic [9:0] frame;
        frame = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            drive_rx(sel, frame[i]);
            repeat (cpb) @(negedge clk);
        end
        drive_rx(sel, 1'b1);
        repeat (4) @(negedge clk);
    endtask

    task automatic apply_reset();
        rst  = 1'b1;
        rx_s = 1'b1; rx_f = 1'b1; rx_m = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [127:0] pack_word(input logic [7:0] b[16]);
        logic [127:0] w;
        w = '0;
        for (int k = 0; k < 16; k++) w = w | (128'(b[k]) << (8 * k));
        return w;
    endfunction

    task automatic test_reset();
        rst  = 1'b1;
        rx_s = 1'b1; rx_f = 1'b1; rx_m = 1'b1;
        en_s = 1'b0; en_f = 1'b0; en_m = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++; if (empty_f !== 1'b1) begin n_err++; $display("FAIL reset_empty: got %b expected 1", empty_f); end
        n_vec++; if (full_f !== 1'b0) begin n_err++; $display("FAIL reset_full: got %b expected 0", full_f); end
        n_vec++; if (wv_f !== 1'b0) begin n_err++; $display("FAIL reset_word_valid: got %b expected 0", wv_f); end
        n_vec++; if (wo_f !== 128'h0) begin n_err++; $display("FAIL reset_word_out: got %h expected 0", wo_f); end
        n_vec++; if (u_fast.u_uart_rx.r_state !== ST_IDLE) begin n_err++; $display("FAIL reset_state: got %0d expected %0d", u_fast.u_uart_rx.r_state, ST_IDLE); end
        n_vec++; if (empty_m !== 1'b1 || full_m !== 1'b0) begin n_err++; $display("FAIL reset_small_flags: got empty=%b full=%b expected empty=1 full=0", empty_m, full_m); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_byte();
        got_s.delete();
        en_s = 1'b0;
        uart_send(0, 8'hF0, 1'b1, CPB_SLOW);
        repeat (4) @(negedge clk);
        n_vec++; if (u_slow.SYNC_FIFO_DUT.mem[0] !== 8'hF0) begin n_err++; $display("FAIL slow_mem0: got %h expected f0", u_slow.SYNC_FIFO_DUT.mem[0]); end
        n_vec++; if (empty_s !== 1'b0) begin n_err++; $display("FAIL slow_empty: got %b expected 0", empty_s); end
        n_vec++; if (got_s.size() != 0) begin n_err++; $display("FAIL slow_no_word: got %0d words expected 0", got_s.size()); end
    endtask

    task automatic test_fill_and_drain();
        logic [7:0] q[$];
        logic [7:0] chunk[16];
        apply_reset();
        got_f.delete();
        en_f = 1'b0;
        for (int i = 0; i < 32; i++) begin
            logic [7:0] b;
            b = (i < 16) ? 8'(8'hF0 + i) : 8'(8'hA0 + i - 16);
            uart_send(1, b, 1'b1, CPB_FAST);
            q.push_back(b);
        end
        for (int i = 0; i < 32; i++) begin
            n_vec++;
            if (u_fast.SYNC_FIFO_DUT.mem[i] !== q[i]) begin
                n_err++; $display("FAIL fill_mem[%0d]: got %h expected %h", i, u_fast.SYNC_FIFO_DUT.mem[i], q[i]);
            end
        end
        n_vec++; if (got_f.size() != 0) begin n_err++; $display("FAIL fill_no_word: got %0d words expected 0", got_f.size()); end
        en_f = 1'b1;
        for (int c = 0; c < 2000 && got_f.size() < 2; c++) @(negedge clk);
        repeat (50) @(negedge clk);
        n_vec++; if (got_f.size() != 2) begin n_err++; $display("FAIL drain_count: got %0d words expected 2", got_f.size()); end
        for (int w = 0; w < 2; w++) begin
            for (int k = 0; k < 16; k++) chunk[k] = q[16 * w + k];
            n_vec++;
            if (got_f.size() <= w) begin
                n_err++; $display("FAIL drain_word%0d: got none expected %h", w, pack_word(chunk));
            end else if (got_f[w] !== pack_word(chunk)) begin
                n_err++; $display("FAIL drain_word%0d: got %h expected %h", w, got_f[w], pack_word(chunk));
            end
        end
        n_vec++; if (empty_f !== 1'b1) begin n_err++; $display("FAIL drain_empty: got %b expected 1", empty_f); end
        en_f = 1'b0;
    endtask

    task automatic test_framing_error();
        apply_reset();
        en_f = 1'b0;
        uart_send(1, 8'h3C, 1'b0, CPB_FAST);
        repeat (3 * CPB_FAST) @(negedge clk);
        n_vec++; if (empty_f !== 1'b1) begin n_err++; $display("FAIL frame_err_no_write: got empty=%b expected 1", empty_f); end
        n_vec++; if (u_fast.u_uart_rx.r_state !== ST_IDLE) begin n_err++; $display("FAIL frame_err_state: got %0d expected %0d", u_fast.u_uart_rx.r_state, ST_IDLE); end
    endtask

    task automatic test_glitch();
        apply_reset();
        en_f = 1'b0;
        rx_f = 1'b0;
        repeat (CPB_FAST / 4) @(negedge clk);
        rx_f = 1'b1;
        repeat (2 * CPB_FAST) @(negedge clk);
        n_vec++; if (empty_f !== 1'b1) begin n_err++; $display("FAIL glitch_no_write: got empty=%b expected 1", empty_f); end
        n_vec++; if (u_fast.u_uart_rx.r_state !== ST_IDLE) begin n_err++; $display("FAIL glitch_state: got %0d expected %0d", u_fast.u_uart_rx.r_state, ST_IDLE); end
    endtask

    task automatic test_reset_mid_frame();
        apply_reset();
        en_f = 1'b0;
        rx_f = 1'b0;
        repeat (3 * CPB_FAST) @(negedge clk);
        rst  = 1'b1;
        rx_f = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2 * CPB_FAST) @(negedge clk);
        n_vec++; if (empty_f !== 1'b1) begin n_err++; $display("FAIL abort_no_write: got empty=%b expected 1", empty_f); end
        uart_send(1, 8'h5A, 1'b1, CPB_FAST);
        repeat (4) @(negedge clk);
        n_vec++; if (u_fast.SYNC_FIFO_DUT.mem[0] !== 8'h5A) begin n_err++; $display("FAIL abort_mem0: got %h expected 5a", u_fast.SYNC_FIFO_DUT.mem[0]); end
        n_vec++; if (u_fast.SYNC_FIFO_DUT.r_wr_ptr !== 11'd1) begin n_err++; $display("FAIL abort_one_entry: got wr_ptr=%0d expected 1", u_fast.SYNC_FIFO_DUT.r_wr_ptr); end
        // Written by the fill test and untouched by any reset since
        n_vec++; if (u_fast.SYNC_FIFO_DUT.mem[1] !== 8'hF1) begin n_err++; $display("FAIL mem_kept_over_reset: got %h expected f1", u_fast.SYNC_FIFO_DUT.mem[1]); end
    endtask

    task automatic test_random_stream();
        logic [7:0] q[$];
        logic [7:0] chunk[16];
        logic [127:0] last;
        apply_reset();
        got_f.delete();
        for (int i = 0; i < 48; i++) begin
            logic [7:0] b;
            en_f = 1'($urandom_range(0, 1));
            b = 8'($urandom);
            uart_send(1, b, 1'b1, CPB_FAST);
            q.push_back(b);
            repeat ($urandom_range(0, 20)) @(negedge clk);
        end
        en_f = 1'b1;
        for (int c = 0; c < 3000 && got_f.size() < 3; c++) @(negedge clk);
        repeat (40) @(negedge clk);
        n_vec++; if (got_f.size() != 3) begin n_err++; $display("FAIL rand_count: got %0d words expected 3", got_f.size()); end
        last = '0;
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < 16; k++) chunk[k] = q[16 * w + k];
            last = pack_word(chunk);
            n_vec++;
            if (got_f.size() <= w) begin
                n_err++; $display("FAIL rand_word%0d: got none expected %h", w, last);
            end else if (got_f[w] !== last) begin
                n_err++; $display("FAIL rand_word%0d: got %h expected %h", w, got_f[w], last);
            end
        end
        n_vec++; if (wo_f !== last) begin n_err++; $display("FAIL rand_word_hold: got %h expected %h", wo_f, last); end
        n_vec++; if (empty_f !== 1'b1) begin n_err++; $display("FAIL rand_empty: got %b expected 1", empty_f); end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] chunk[16];
        apply_reset();
        got_f.delete();
        en_f = 1'b1;
        for (int i = 0; i < 5; i++) uart_send(1, 8'($urandom), 1'b1, CPB_FAST);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 16; i++) begin
            chunk[i] = 8'($urandom);
            uart_send(1, chunk[i], 1'b1, CPB_FAST);
        end
        for (int c = 0; c < 200 && got_f.size() < 1; c++) @(negedge clk);
        repeat (10) @(negedge clk);
        n_vec++; if (got_f.size() != 1) begin n_err++; $display("FAIL midword_count: got %0d words expected 1", got_f.size()); end
        n_vec++;
        if (got_f.size() < 1) begin
            n_err++; $display("FAIL midword_word: got none expected %h", pack_word(chunk));
        end else if (got_f[0] !== pack_word(chunk)) begin
            n_err++; $display("FAIL midword_word: got %h expected %h", got_f[0], pack_word(chunk));
        end
        en_f = 1'b0;
    endtask

    task automatic test_full_drop();
        logic [7:0] b[5];
        apply_reset();
        en_m = 1'b0;
        for (int i = 0; i < 5; i++) b[i] = 8'($urandom);
        for (int i = 0; i < 3; i++) uart_send(2, b[i], 1'b1, CPB_FAST);
        n_vec++; if (full_m !== 1'b0) begin n_err++; $display("FAIL full_after3: got %b expected 0", full_m); end
        uart_send(2, b[3], 1'b1, CPB_FAST);
        n_vec++; if (full_m !== 1'b1) begin n_err++; $display("FAIL full_after4: got %b expected 1", full_m); end
        uart_send(2, ~b[0], 1'b1, CPB_FAST);
        n_vec++; if (full_m !== 1'b1) begin n_err++; $display("FAIL full_after5: got %b expected 1", full_m); end
        for (int i = 0; i < 4; i++) begin
            n_vec++;
            if (u_small.SYNC_FIFO_DUT.mem[i] !== b[i]) begin
                n_err++; $display("FAIL full_mem[%0d]: got %h expected %h", i, u_small.SYNC_FIFO_DUT.mem[i], b[i]);
            end
        end
        n_vec++; if (got_m.size() != 0) begin n_err++; $display("FAIL full_no_word: got %0d words expected 0", got_m.size()); end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_fill_and_drain();
        test_framing_error();
        test_glitch();
        test_reset_mid_frame();
        test_random_stream();
        test_reset_mid_word();
        test_full_drop();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
